// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: word width,
// access-size and FSM state encodings, and the alignment rule.
package dmem_access_ctrl_pkg;

    localparam int WORD = 64;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_REQ  = 2'd1,
        DM_DONE = 2'd2
    } dm_state_e;

    // An access is misaligned when the address is not a multiple of its size.
    function automatic logic misaligned(input logic [2:0] offset, input logic [1:0] size);
        case (size_e'(size))
            SZ_B:    return 1'b0;
            SZ_H:    return offset[0];
            SZ_W:    return |offset[1:0];
            default: return |offset;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_lane.sv
// Combinational byte-lane alignment: byte enables, store-data shift and
// load extract with zero/sign extension (little-endian doubleword port).
module dmem_lane_align
    import dmem_access_ctrl_pkg::*;
(
    input  logic [1:0]      size,
    input  logic            sign_ext,
    input  logic [2:0]      offset,
    input  logic [WORD-1:0] w_data,
    input  logic [WORD-1:0] rdata,
    output logic [7:0]      be,
    output logic [WORD-1:0] wdata,
    output logic [WORD-1:0] load_data
);

    logic [5:0]      shamt;
    logic [WORD-1:0] shifted;

    assign shamt   = {offset, 3'b000};
    assign shifted = rdata >> shamt;
    assign wdata   = w_data << shamt;

    // NOTE: every output of an always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        case (size_e'(size))
            SZ_B: begin
                be        = 8'h01 << offset;
                load_data = {{(WORD-8){sign_ext & shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                be        = 8'h03 << offset;
                load_data = {{(WORD-16){sign_ext & shifted[15]}}, shifted[15:0]};
            end
            SZ_W: begin
                be        = 8'h0F << offset;
                load_data = {{(WORD-32){sign_ext & shifted[31]}}, shifted[31:0]};
            end
            default: begin
                be        = 8'hFF << offset;
                load_data = shifted;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Multi-cycle data-memory access controller (IDLE -> REQ -> DONE) with stall.
// Optional REQ timeout is enabled by defining DMEM_TIMEOUT_EN.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic [1:0]      size,
    input  logic            sign_ext,
    input  logic [WORD-1:0] addr,
    input  logic [WORD-1:0] w_data,
    output logic [WORD-1:0] r_data,
    output logic            stall,
    output logic            mem_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [WORD-1:0] mem_addr,
    output logic [7:0]      mem_be,
    output logic [WORD-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [WORD-1:0] mem_rdata
);

    dm_state_e       state, next_state;
    logic            req, mis, expire;
    logic [2:0]      off_q;
    logic [1:0]      size_q;
    logic            sext_q, we_q;
    logic [7:0]      lane_be;
    logic [WORD-1:0] lane_wdata, lane_load;

    assign req = MemRead | MemWrite;
    assign mis = misaligned(addr[2:0], size);

    // Live inputs drive the lanes while accepting; latched values afterwards.
    dmem_lane_align u_lane (
        .size      (state == DM_IDLE ? size      : size_q),
        .sign_ext  (state == DM_IDLE ? sign_ext  : sext_q),
        .offset    (state == DM_IDLE ? addr[2:0] : off_q),
        .w_data    (w_data),
        .rdata     (mem_rdata),
        .be        (lane_be),
        .wdata     (lane_wdata),
        .load_data (lane_load)
    );

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != DM_REQ) tmo_cnt <= '0;
        else if (!mem_ack)          tmo_cnt <= tmo_cnt + 1'b1;
    end

    // The count reaches TIMEOUT_CYCLES at the edge ending this cycle; ack wins.
    assign expire = (state == DM_REQ) && !mem_ack && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign expire = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) state <= DM_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            DM_IDLE: if (req) next_state = mis ? DM_DONE : DM_REQ;
            DM_REQ:  if (mem_ack || expire) next_state = DM_DONE;
            default: next_state = DM_IDLE;
        endcase
    end

    always_comb begin
        stall = ((state == DM_IDLE) && req) || (state == DM_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            off_q     <= '0;
            size_q    <= '0;
            sext_q    <= 1'b0;
            we_q      <= 1'b0;
            r_data    <= '0;
            mem_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                DM_IDLE: begin
                    if (req) begin
                        off_q  <= addr[2:0];
                        size_q <= size;
                        sext_q <= sign_ext;
                        we_q   <= MemWrite;
                        if (mis) begin
                            mem_err <= 1'b1;
                            r_data  <= '0;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= MemWrite;
                            mem_addr  <= {addr[WORD-1:3], 3'b000};
                            mem_be    <= lane_be;
                            mem_wdata <= lane_wdata;
                        end
                    end
                end
                DM_REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!we_q) r_data <= lane_load;
                    end else if (expire) begin
                        mem_req <= 1'b0;
                        mem_err <= 1'b1;
                        r_data  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed cases plus randomized
// aligned accesses compared against a byte-level reference model.
module tb_dmem_access_ctrl;
    import dmem_access_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemRead = 1'b0, MemWrite = 1'b0, sign_ext = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [63:0] addr = '0, w_data = '0, mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [63:0] r_data, mem_addr, mem_wdata;
    logic        stall, mem_err, mem_req, mem_we;
    logic [7:0]  mem_be;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] r_model = '0;
    logic        err_model = 1'b0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .size(size), .sign_ext(sign_ext), .addr(addr), .w_data(w_data),
        .r_data(r_data), .stall(stall), .mem_err(mem_err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: byte-by-byte view of the little-endian port.
    function automatic logic [7:0] be_ref(input logic [2:0] off, input logic [1:0] sz);
        logic [7:0] b = '0;
        for (int i = 0; i < (1 << sz); i++) b[off + i] = 1'b1;
        return b;
    endfunction

    function automatic logic [63:0] wdata_ref(input logic [63:0] wd, input logic [2:0] off);
        logic [63:0] v = '0;
        for (int i = 0; i + off < 8; i++) v[8*(i+off) +: 8] = wd[8*i +: 8];
        return v;
    endfunction

    function automatic logic [63:0] load_ref(input logic [63:0] rd, input logic [2:0] off,
                                             input logic [1:0] sz, input logic sx);
        int          nb = 1 << sz;
        logic [63:0] v  = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
        if (sx && v[8*nb-1])
            for (int i = 8*nb; i < 64; i++) v[i] = 1'b1;
        return v;
    endfunction

    // One aligned access; memory acks after 'waits' extra REQ cycles.
    task automatic access(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic sx, input logic [63:0] a, input logic [63:0] wd,
                          input logic [63:0] rdat, input int waits);
        int req_cycles;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; size = sz; sign_ext = sx; addr = a; w_data = wd;
        #1 check({tag, ".stall0"}, 64'(stall), 64'd1);
        @(negedge clk);
        check({tag, ".req"},   64'(mem_req), 64'd1);
        check({tag, ".stall1"}, 64'(stall), 64'd1);
        check({tag, ".we"},    64'(mem_we), 64'(wr));
        check({tag, ".addr"},  mem_addr, {a[63:3], 3'b000});
        check({tag, ".be"},    64'(mem_be), 64'(be_ref(a[2:0], sz)));
        check({tag, ".wdata"}, mem_wdata, wdata_ref(wd, a[2:0]));
        req_cycles = 1;
        repeat (waits) begin
            @(negedge clk);
            req_cycles += int'(mem_req);
        end
        mem_ack = 1'b1; mem_rdata = rdat;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = {$urandom(), $urandom()};
        if (!wr) r_model = load_ref(rdat, a[2:0], sz, sx);
        check({tag, ".req_cycles"}, 64'(req_cycles), 64'(waits + 1));
        check({tag, ".done_stall"}, 64'(stall), 64'd0);
        check({tag, ".done_req"},  64'(mem_req), 64'd0);
        check({tag, ".r_data"},    r_data, r_model);
        check({tag, ".err"},       64'(mem_err), 64'(err_model));
        MemRead = 1'b0; MemWrite = 1'b0;
        @(negedge clk);
        check({tag, ".idle_stall"}, 64'(stall), 64'd0);
        check({tag, ".idle_req"},   64'(mem_req), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".req"},   64'(mem_req), 64'd0);
        check({tag, ".we"},    64'(mem_we), 64'd0);
        check({tag, ".be"},    64'(mem_be), 64'd0);
        check({tag, ".addr"},  mem_addr, 64'd0);
        check({tag, ".wdata"}, mem_wdata, 64'd0);
        check({tag, ".rdata"}, r_data, 64'd0);
        check({tag, ".err"},   64'(mem_err), 64'd0);
        check({tag, ".stall"}, 64'(stall), 64'd0);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [2:0]  off;
        logic [63:0] a;
        logic        wr, rd;
        int          cnt;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        access("ldur", 1'b1, 1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 64'h1122334455667788, 0);
        check("ldur.const", r_data, 64'h1122334455667788);

        access("ldursw", 1'b1, 1'b0, 2'd2, 1'b1, 64'h1C, 64'h0, 64'h80000001_00000000, 0);
        check("ldursw.const", r_data, 64'hFFFFFFFF80000001);

        access("sturb", 1'b0, 1'b1, 2'd0, 1'b0, 64'h23, 64'hAB, 64'hDEAD_BEEF_0000_0000, 5);
        check("sturb.be",    64'(mem_be), 64'h08);
        check("sturb.wdata", mem_wdata, 64'hAB000000);
        check("sturb.rdata", r_data, 64'hFFFFFFFF80000001);

        for (int i = 0; i < 16; i++) begin
            sz  = 2'($urandom_range(3, 0));
            off = 3'(($urandom_range(7, 0) >> sz) << sz);
            a   = {$urandom(), $urandom()};
            a[2:0] = off;
            wr  = 1'($urandom_range(1, 0));
            rd  = wr ? 1'($urandom_range(1, 0)) : 1'b1;
            access($sformatf("rnd%0d", i), rd, wr, sz, 1'($urandom_range(1, 0)), a,
                   {$urandom(), $urandom()}, {$urandom(), $urandom()}, int'($urandom_range(3, 0)));
        end

        // Misaligned half load: no transaction, error and zero result.
        @(negedge clk);
        MemRead = 1'b1; size = 2'd1; addr = 64'h5;
        #1 check("mis.stall0", 64'(stall), 64'd1);
        @(negedge clk);
        r_model = '0; err_model = 1'b1;
        check("mis.req",   64'(mem_req), 64'd0);
        check("mis.err",   64'(mem_err), 64'd1);
        check("mis.rdata", r_data, 64'd0);
        check("mis.stall", 64'(stall), 64'd0);
        MemRead = 1'b0;
        @(negedge clk);
        check("mis.idle_stall", 64'(stall), 64'd0);
        check("mis.idle_req",   64'(mem_req), 64'd0);

        access("after_mis", 1'b1, 1'b0, 2'd1, 1'b1, 64'h106, 64'h0, 64'h8001_0000_0000_0000, 1);

        // Reset while in REQ, then an ack that must be ignored.
        @(negedge clk);
        MemRead = 1'b1; size = 2'd3; addr = 64'h80;
        @(negedge clk);
        check("rst.req_before", 64'(mem_req), 64'd1);
        rst = 1'b1; MemRead = 1'b0;
        @(negedge clk);
        r_model = '0; err_model = 1'b0;
        check_reset_values("rst");
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        check("rst.ack_req",   64'(mem_req), 64'd0);
        check("rst.ack_rdata", r_data, 64'd0);
        check("rst.ack_stall", 64'(stall), 64'd0);
        access("after_rst", 1'b1, 1'b0, 2'd0, 1'b1, 64'h81, 64'h0, 64'h0000_0000_0000_F700, 0);

`ifdef DMEM_TIMEOUT_EN
        @(negedge clk);
        MemRead = 1'b1; size = 2'd3; addr = 64'h200;
        @(negedge clk);
        cnt = 0;
        while (mem_req && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        r_model = '0; err_model = 1'b1;
        check("tmo.req_cycles", 64'(cnt), 64'd4);
        check("tmo.err",   64'(mem_err), 64'd1);
        check("tmo.rdata", r_data, 64'd0);
        check("tmo.stall", 64'(stall), 64'd0);
        MemRead = 1'b0;
        @(negedge clk);
`else
        cnt = 0;
        access("no_tmo", 1'b1, 1'b0, 2'd3, 1'b0, 64'h200, 64'h0, 64'h0123_4567_89AB_CDEF, 20);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Multi-cycle data-memory access controller sitting directly downstream of the single-cycle datapath's ALU/store-data outputs. It converts the datapath's `ALUOut` address, `MemData` store data and load/store controls into a req/ack transaction on a 64-bit doubleword-wide memory port. It aligns byte lanes, returns extended load data as `r_data`, and holds the datapath with `stall` until the access completes.

## Interface
- `WORD`, 64: data/address width (from `common.vh`).
- `TIMEOUT_CYCLES`, 255: max cycles in REQ before abort (used only with `DMEM_TIMEOUT_EN`).

- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `MemRead` input 1: load request from control unit.
- `MemWrite` input 1: store request from control unit.
- `size` input 2: 0=byte, 1=half, 2=word, 3=doubleword.
- `sign_ext` input 1: sign-extend load result (LDURSW); otherwise zero-extend.
- `addr` input WORD: byte address (datapath `ALUOut`).
- `w_data` input WORD: store data (datapath `MemData`), LSB-justified.
- `r_data` output WORD: load result to write-back.
- `stall` output 1: datapath must hold PC and instruction.
- `mem_err` output 1: sticky error (misalign/timeout).
- `mem_req` output 1: memory request, registered.
- `mem_we` output 1: 1=write.
- `mem_addr` output WORD: `{addr[63:3],3'b000}`.
- `mem_be` output 8: byte enables.
- `mem_wdata` output WORD: lane-shifted store data.
- `mem_ack` input 1: memory completion, one-cycle pulse.
- `mem_rdata` input WORD: read doubleword, valid with `mem_ack`.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If `MemRead|MemWrite`, latch `addr`, `size`, `sign_ext`, `w_data`, op. Go to REQ, or to DONE with `mem_err` set if misaligned.
  - `MemWrite` takes priority when both inputs are high.
- Misaligned: `addr` not a multiple of 2^`size`. No memory transaction is issued, `r_data`=0.
- REQ:
  - `mem_req`=1; all `mem_*` outputs stable from latched values.
  - On `mem_ack`: for loads, register extracted and extended data into `r_data`. Go to DONE.
  - Otherwise remain in REQ.
- DONE: `stall`=0 for one cycle while the datapath commits. Always return to IDLE; the request still visible this cycle is not re-accepted.
- Lane rules:
  - `mem_be` = (2^(2^`size`)−1) << `addr[2:0]`.
  - `mem_wdata` = `w_data` << (8·`addr[2:0]`).
  - Load = (`mem_rdata` >> (8·`addr[2:0]`)) truncated to 2^`size` bytes, then zero/sign-extended to WORD. Little-endian.
- `mem_ack` in IDLE or DONE is ignored.
- `r_data` holds its last value until the next load completes. A store leaves `r_data` unchanged.

## Timing
- Reset values: state IDLE, `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0, `r_data`=0, `mem_err`=0, `stall`=0.
- `stall` is combinational: high in IDLE when a request is present, and high throughout REQ; low in DONE and in an idle IDLE.
- Cycle 0: IDLE sees request, `stall`=1. Cycle 1: `mem_req`=1. Earliest `mem_ack` is in cycle 1; the following cycle is DONE. Minimum access time: 3 cycles, 2 of them stalled.
- Misaligned access: cycle 0 IDLE (`stall`=1). Cycle 1 DONE with `mem_err`=1, `r_data`=0.
- `rst` in any state takes effect at the next edge: `mem_req` drops, FSM goes to IDLE, `mem_err` clears. A pending ack is discarded.

## Configuration
- `DMEM_TIMEOUT_EN` defined:
  - Counter clears on REQ entry and increments each REQ cycle without ack.
  - When the count reaches `TIMEOUT_CYCLES`, the controller drops `mem_req`, sets `mem_err`, sets `r_data`=0 and goes to DONE.
  - An ack in the same cycle as expiry wins; no error is flagged.
- Not defined: no counter; REQ waits indefinitely for `mem_ack`.

## Structure
- Shared package / `common.vh`:
  - `WORD`.
  - Size encodings `SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`.
  - FSM state encodings `DM_IDLE`, `DM_REQ`, `DM_DONE`.
- Sub-module `dmem_lane_align` (combinational): byte-enable generation, store shift, load extract/extend.
- FSM, latches and timeout counter live in the top.

## Test plan
- Aligned LDUR: `addr`=0x10, `size`=3, ack on the first REQ cycle with `mem_rdata`=0x1122334455667788 → `mem_addr`=0x10, `mem_be`=0xFF, `stall` high for 2 cycles, `r_data`=0x1122334455667788 in DONE.
- LDURSW: `addr`=0x1C, `size`=2, `sign_ext`=1, `mem_rdata`=0x80000001_00000000 → `mem_be`=0xF0, `r_data`=0xFFFFFFFF80000001.
- STURB: `addr`=0x23, `w_data`=0xAB, ack after 5 wait cycles → `mem_we`=1, `mem_be`=0x08, `mem_wdata`=0xAB000000, `mem_req` held 6 cycles, `r_data` unchanged.
- Misaligned half load at `addr`=0x5 → no `mem_req`, `mem_err`=1 in the next cycle, `r_data`=0, then IDLE.
- `rst` asserted in REQ with ack arriving the next cycle → all outputs return to reset values, ack ignored, next request accepted normally.
- With `DMEM_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, no ack → `mem_req` drops after 4 REQ cycles, `mem_err`=1, `stall` released in DONE.
